wb_bridge_slave: RTL and testbench



---
 rtl/wb_bridge_slave.sv | 169 ++++++++++++++++
 tb/tb_wb_bridge_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bridge_slave.sv
// wb_bridge_slave: Wishbone responder that replays one transaction at a time on an
// Ibex-style req/gnt/rvalid device port and returns a single-cycle ack or error.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   scyc_i .. ssel_i      Wishbone slave inputs (cycle, strobe, we, address, data, sel)
//   sstall_o              high while a transaction is in flight
//   sack_o / serr_o       one-cycle response pulses, mutually exclusive
//   sdata_o               read data, valid with sack_o
//   dev_req_o .. dev_*_o  registered device request and latched fields
//   dev_gnt_i             device grant
//   dev_rvalid_i          device response valid, qualifies dev_rdata_i and dev_err_i
module wb_bridge_slave #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    scyc_i,
    input  logic                    sstb_i,
    input  logic                    swe_i,
    input  logic [ADDR_WIDTH-1:0]   saddr_i,
    input  logic [DATA_WIDTH-1:0]   sdata_i,
    input  logic [DATA_WIDTH/8-1:0] ssel_i,
    output logic                    sstall_o,
    output logic                    sack_o,
    output logic [DATA_WIDTH-1:0]   sdata_o,
    output logic                    serr_o,
    output logic                    dev_req_o,
    input  logic                    dev_gnt_i,
    output logic                    dev_we_o,
    output logic [DATA_WIDTH/8-1:0] dev_be_o,
    output logic [ADDR_WIDTH-1:0]   dev_addr_o,
    output logic [DATA_WIDTH-1:0]   dev_wdata_o,
    input  logic                    dev_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   dev_rdata_i,
    input  logic                    dev_err_i
);

    // Counter is wide enough to step past TIMEOUT_CYCLES-1, so after a grant that
    // coincides with expiry it cannot match again.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_abort;
    logic                    r_sstall;
    logic                    r_sack;
    logic                    r_serr;
    logic [DATA_WIDTH-1:0]   r_sdata;
    logic                    r_dev_req;
    logic                    r_dev_we;
    logic [DATA_WIDTH/8-1:0] r_dev_be;
    logic [ADDR_WIDTH-1:0]   r_dev_addr;
    logic [DATA_WIDTH-1:0]   r_dev_wdata;

    logic w_accept;
    logic w_busy;
    logic w_abort;
    logic w_expire;
    logic w_timeout;

    assign w_accept = scyc_i & sstb_i & ~r_sstall;
    assign w_busy   = (r_state == S_REQ) || (r_state == S_RESP);
    // Abort also covers the cycle in which scyc_i first drops.
    assign w_abort  = r_abort | ~scyc_i;
    assign w_expire = TO_EN && (r_cnt == CNT_LAST);
    // The exiting event (gnt or rvalid) beats an expiry on the same edge.
    assign w_timeout = w_expire && (((r_state == S_REQ) && !dev_gnt_i) ||
                                    ((r_state == S_RESP) && !dev_rvalid_i));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_abort     <= 1'b0;
            r_sstall    <= 1'b0;
            r_sack      <= 1'b0;
            r_serr      <= 1'b0;
            r_sdata     <= '0;
            r_dev_req   <= 1'b0;
            r_dev_we    <= 1'b0;
            r_dev_be    <= '0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
        end else begin
            if (w_busy) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_abort <= w_abort;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_REQ;
                        r_sstall    <= 1'b1;
                        r_dev_req   <= 1'b1;
                        r_dev_we    <= swe_i;
                        r_dev_addr  <= saddr_i;
                        r_dev_wdata <= sdata_i;
                        r_dev_be    <= ssel_i;
                        r_cnt       <= '0;
                        r_abort     <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (dev_gnt_i) begin
                        r_dev_req <= 1'b0;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (dev_rvalid_i) begin
                        r_state <= S_ACK;
                        r_sdata <= r_dev_we ? '0 : dev_rdata_i;
                        r_sack  <= !dev_err_i && !w_abort;
                        r_serr  <= dev_err_i && !w_abort;
                    end
                end
                S_ACK: begin
                    r_state  <= S_IDLE;
                    r_sack   <= 1'b0;
                    r_serr   <= 1'b0;
                    r_sdata  <= '0;
                    r_sstall <= 1'b0;
                    r_abort  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            // Timeout drops req without waiting for gnt; an aborted transfer skips ACK.
            if (w_timeout) begin
                r_dev_req <= 1'b0;
                r_sdata   <= '0;
                if (w_abort) begin
                    r_state  <= S_IDLE;
                    r_sstall <= 1'b0;
                    r_abort  <= 1'b0;
                end else begin
                    r_state <= S_ACK;
                    r_serr  <= 1'b1;
                end
            end
        end
    end

    assign sstall_o    = r_sstall;
    assign sack_o      = r_sack;
    assign serr_o      = r_serr;
    assign sdata_o     = r_sdata;
    assign dev_req_o   = r_dev_req;
    assign dev_we_o    = r_dev_we;
    assign dev_be_o    = r_dev_be;
    assign dev_addr_o  = r_dev_addr;
    assign dev_wdata_o = r_dev_wdata;

endmodule

// File: tb/tb_wb_bridge_slave.sv
// Testbench for wb_bridge_slave: directed transactions, a timestamp-based
// transaction model checked every cycle, and literal expectations at key cycles.
module tb_wb_bridge_slave;

    localparam int TO = 8;

    logic        clk;
    logic        t_reset;
    logic        t_cyc;
    logic        t_stb;
    logic        t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_sel;
    logic        t_gnt;
    logic        t_rvalid;
    logic [31:0] t_rdata;
    logic        t_err;

    logic        d_stall;
    logic        d_ack;
    logic [31:0] d_sdata;
    logic        d_serr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    wb_bridge_slave #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (t_reset),
        .scyc_i       (t_cyc),
        .sstb_i       (t_stb),
        .swe_i        (t_we),
        .saddr_i      (t_addr),
        .sdata_i      (t_wdata),
        .ssel_i       (t_sel),
        .sstall_o     (d_stall),
        .sack_o       (d_ack),
        .sdata_o      (d_sdata),
        .serr_o       (d_serr),
        .dev_req_o    (d_req),
        .dev_gnt_i    (t_gnt),
        .dev_we_o     (d_we),
        .dev_be_o     (d_be),
        .dev_addr_o   (d_addr),
        .dev_wdata_o  (d_wdata),
        .dev_rvalid_i (t_rvalid),
        .dev_rdata_i  (t_rdata),
        .dev_err_i    (t_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: times are counted in cycles since the acceptance edge.
    // A transaction is in flight from acceptance until the cycle after its response.
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_abort = 1'b0;
    bit          m_err   = 1'b0;
    int          m_age, m_gnt_at, m_resp_at;
    logic [31:0] m_rd, m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_we;
    logic        e_stall, e_req, e_ack, e_serr;
    logic [31:0] e_sdata;

    task model_timeout();
        if (m_abort) begin
            m_busy = 1'b0;
        end else begin
            m_resp_at = m_age;
            m_err     = 1'b1;
            m_rd      = '0;
        end
    endtask

    task model_step();
        bit  expire;
        bit  in_ack;
        if (t_reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_abort = 1'b0;
            m_we    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_be    = '0;
        end else if (!m_busy) begin
            if (t_cyc && t_stb) begin
                m_busy    = 1'b1;
                m_age     = 0;
                m_gnt_at  = 0;
                m_resp_at = 0;
                m_abort   = 1'b0;
                m_err     = 1'b0;
                m_rd      = '0;
                m_we      = t_we;
                m_addr    = t_addr;
                m_wdata   = t_wdata;
                m_be      = t_sel;
            end
        end else if (m_resp_at != 0) begin
            m_busy = 1'b0;
        end else begin
            if (!t_cyc) m_abort = 1'b1;
            expire = (TO != 0) && (m_age - 1 == TO - 1);
            if (m_gnt_at == 0) begin
                if (t_gnt) m_gnt_at = m_age;
                else if (expire) model_timeout();
            end else if (t_rvalid) begin
                m_resp_at = m_age;
                m_err     = t_err;
                m_rd      = m_we ? 32'h0 : t_rdata;
            end else if (expire) begin
                model_timeout();
            end
        end
        m_age++;
        in_ack  = m_busy && (m_resp_at != 0) && (m_age == m_resp_at + 1);
        e_stall = m_busy;
        e_req   = m_busy && (m_gnt_at == 0) && (m_resp_at == 0);
        e_ack   = in_ack && !m_err && !m_abort;
        e_serr  = in_ack && m_err && !m_abort;
        e_sdata = in_ack ? m_rd : 32'h0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cyc_stall", d_stall, e_stall);
            chk("cyc_req",   d_req,   e_req);
            chk("cyc_ack",   d_ack,   e_ack);
            chk("cyc_serr",  d_serr,  e_serr);
            chk("cyc_sdata", d_sdata, e_sdata);
            chk("cyc_we",    d_we,    m_we);
            chk("cyc_be",    d_be,    m_be);
            chk("cyc_addr",  d_addr,  m_addr);
            chk("cyc_wdata", d_wdata, m_wdata);
        end
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns in the first REQ cycle with stb dropped.
    task start(input logic we, input logic [31:0] addr, input logic [31:0] data,
               input logic [3:0] sel);
        t_cyc   = 1'b1;
        t_stb   = 1'b1;
        t_we    = we;
        t_addr  = addr;
        t_wdata = data;
        t_sel   = sel;
        tick();
        t_stb = 1'b0;
    endtask

    // Zero-wait device completion from the first REQ cycle; returns in the ACK cycle.
    task zero_wait(input logic [31:0] rdata, input logic err);
        t_gnt = 1'b1;
        tick();
        t_gnt    = 1'b0;
        t_rvalid = 1'b1;
        t_rdata  = rdata;
        t_err    = err;
        tick();
        t_rvalid = 1'b0;
        t_err    = 1'b0;
    endtask

    initial begin
        t_reset = 1'b1; t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        t_addr = '0; t_wdata = '0; t_sel = '0;
        t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0; t_err = 1'b0;
        tick();
        tick();
        t_reset = 1'b0;
        chk("rst_stall", d_stall, 1'b0);
        chk("rst_req",   d_req,   1'b0);
        chk("rst_addr",  d_addr,  32'h0);
        chk("rst_sdata", d_sdata, 32'h0);
        tick();

        // Zero-wait write.
        start(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
        chk("w_req",   d_req,   1'b1);
        chk("w_addr",  d_addr,  32'h1000_0010);
        chk("w_wdata", d_wdata, 32'hDEAD_BEEF);
        chk("w_be",    d_be,    4'hF);
        chk("w_we",    d_we,    1'b1);
        chk("w_stall", d_stall, 1'b1);
        t_gnt = 1'b1;
        tick();
        chk("w_req_drop", d_req, 1'b0);
        t_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h1111_2222;
        tick();
        chk("w_ack",   d_ack,   1'b1);
        chk("w_serr",  d_serr,  1'b0);
        chk("w_sdata", d_sdata, 32'h0);
        t_rvalid = 1'b0;
        tick();
        chk("w_ack_end", d_ack,   1'b0);
        chk("w_unstall", d_stall, 1'b0);
        t_cyc = 1'b0;
        tick();

        // Read: gnt after two wait cycles, rvalid three cycles after gnt.
        start(1'b0, 32'h1000_0020, 32'h0, 4'hF);
        tick();
        tick();
        t_gnt = 1'b1;
        chk("r_stall", d_stall, 1'b1);
        tick();
        t_gnt = 1'b0;
        tick();
        tick();
        t_rvalid = 1'b1; t_rdata = 32'hA5A5_0001;
        tick();
        t_rvalid = 1'b0;
        chk("r_ack",       d_ack,   1'b1);
        chk("r_sdata",     d_sdata, 32'hA5A5_0001);
        chk("r_stall_ack", d_stall, 1'b1);
        tick();
        chk("r_sdata_clr", d_sdata, 32'h0);
        t_cyc = 1'b0;
        tick();

        // Device error, then an immediate good read and a sel=0 write.
        start(1'b0, 32'h1000_0030, 32'h0, 4'hF);
        zero_wait(32'h0000_0BAD, 1'b1);
        chk("e_serr", d_serr, 1'b1);
        chk("e_ack",  d_ack,  1'b0);
        tick();
        start(1'b0, 32'h1000_0034, 32'h0, 4'h3);
        chk("e2_be", d_be, 4'h3);
        zero_wait(32'h0BAD_F00D, 1'b0);
        chk("e2_ack",   d_ack,   1'b1);
        chk("e2_sdata", d_sdata, 32'h0BAD_F00D);
        tick();
        start(1'b1, 32'h1000_0040, 32'h0000_0055, 4'h0);
        chk("sel0_be", d_be, 4'h0);
        zero_wait(32'h0, 1'b0);
        chk("sel0_ack", d_ack, 1'b1);
        tick();
        t_cyc = 1'b0;
        tick();

        // Timeout: device never grants.
        start(1'b0, 32'h2000_0000, 32'h0, 4'hF);
        for (int k = 1; k < TO; k++) tick();
        chk("to_req_last", d_req, 1'b1);
        tick();
        chk("to_req_drop", d_req,   1'b0);
        chk("to_serr",     d_serr,  1'b1);
        chk("to_ack",      d_ack,   1'b0);
        chk("to_sdata",    d_sdata, 32'h0);
        tick();
        chk("to_idle", d_stall, 1'b0);
        t_cyc = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h77;
        tick();
        t_rvalid = 1'b0;
        chk("to_late_ack",  d_ack,  1'b0);
        chk("to_late_serr", d_serr, 1'b0);
        tick();

        // Abort: cyc dropped after acceptance; gnt at cycle 3, rvalid at cycle 5.
        start(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        t_cyc = 1'b0;
        tick();
        tick();
        t_gnt = 1'b1;
        tick();
        t_gnt = 1'b0;
        tick();
        t_rvalid = 1'b1; t_rdata = 32'h0000_CAFE;
        tick();
        t_rvalid = 1'b0;
        chk("ab_ack",   d_ack,   1'b0);
        chk("ab_serr",  d_serr,  1'b0);
        chk("ab_stall", d_stall, 1'b1);
        // Request presented while stalled; accepted on the following IDLE cycle.
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_addr = 32'h3000_0004; t_sel = 4'hF;
        tick();
        chk("ab_idle", d_stall, 1'b0);
        tick();
        t_stb = 1'b0;
        chk("ab2_req",  d_req,  1'b1);
        chk("ab2_addr", d_addr, 32'h3000_0004);
        zero_wait(32'h600D_0001, 1'b0);
        chk("ab2_ack",   d_ack,   1'b1);
        chk("ab2_sdata", d_sdata, 32'h600D_0001);
        tick();
        t_cyc = 1'b0;
        tick();

        // Reset while waiting for the response.
        start(1'b1, 32'h4000_0000, 32'h0000_0012, 4'hF);
        t_gnt = 1'b1;
        tick();
        t_gnt   = 1'b0;
        t_reset = 1'b1;
        tick();
        chk("rr_stall", d_stall, 1'b0);
        chk("rr_req",   d_req,   1'b0);
        chk("rr_addr",  d_addr,  32'h0);
        chk("rr_we",    d_we,    1'b0);
        t_reset = 1'b0; t_cyc = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h99;
        tick();
        t_rvalid = 1'b0;
        chk("rr_late_ack",  d_ack,  1'b0);
        chk("rr_late_serr", d_serr, 1'b0);
        tick();
        start(1'b0, 32'h4000_0004, 32'h0, 4'hF);
        zero_wait(32'h0123_4567, 1'b0);
        chk("rr2_ack",   d_ack,   1'b1);
        chk("rr2_sdata", d_sdata, 32'h0123_4567);
        tick();
        t_cyc = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
